key_input_conditioner: RTL and testbench

//  Front-end stage feeding the password lock core. Synchronises, debounces and

---
 rtl/key_input_conditioner_if.sv | 34 +++
 rtl/key_input_conditioner.sv | 137 +++++++++++++
 tb/tb_key_input_conditioner.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/key_input_conditioner_if.sv
// Raw key inputs and conditioned event outputs shared between the key front-end
// and the lock core.
interface key_input_conditioner_if;
  logic [9:0] pwds_raw;
  logic       backspace_raw;
  logic       confirm_raw;
  logic       operate_raw;
  logic       admin_raw;
  logic       relieve_raw;

  logic       tick_400hz;
  logic [9:0] pwds_level;
  logic [9:0] digit_pulse;
  logic [3:0] digit_code;
  logic       multi_key;
  logic       backspace_p;
  logic       confirm_p;
  logic       operate_p;
  logic       relieve_p;
  logic       admin_level;
  logic       activity_p;

  modport master (
    output pwds_raw, backspace_raw, confirm_raw, operate_raw, admin_raw, relieve_raw,
    input  tick_400hz, pwds_level, digit_pulse, digit_code, multi_key,
           backspace_p, confirm_p, operate_p, relieve_p, admin_level, activity_p
  );

  modport slave (
    input  pwds_raw, backspace_raw, confirm_raw, operate_raw, admin_raw, relieve_raw,
    output tick_400hz, pwds_level, digit_pulse, digit_code, multi_key,
           backspace_p, confirm_p, operate_p, relieve_p, admin_level, activity_p
  );
endinterface

// File: rtl/key_input_conditioner.sv
// Key front-end: synchronise, debounce and edge-detect the digit switches and
// buttons, producing events stretched to one 400 Hz tick period.
module key_input_conditioner #(
  parameter int TICK_DIV  = 250000,
  parameter int DEB_TICKS = 8
) (
  input logic                     clk_100Mhz,
  input logic                     reset_n,
  key_input_conditioner_if.slave  kif
);

  localparam int NIN = 15;
  localparam int TW  = $clog2(TICK_DIV);
  localparam int CW  = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

  // Input bit map: [9:0] digits, 10 backspace, 11 confirm, 12 operate, 13 admin, 14 relieve
  logic [NIN-1:0] w_raw;
  logic [NIN-1:0] r_sync1;
  logic [NIN-1:0] r_sync2;
  logic [NIN-1:0] r_deb;
  logic [NIN-1:0] r_debOld;
  logic [CW-1:0]  r_debCnt [NIN];
  logic [TW-1:0]  r_tickCnt;
  logic           r_tickD;
  logic           w_tick;

  logic [9:0]     w_pwdsRise;
  logic [9:0]     w_level;
  logic           w_oneHot;
  logic [9:0]     w_digitNext;
  logic [3:0]     w_codeNext;
  logic           w_multiNext;

  logic [9:0]     r_digitPulse;
  logic [3:0]     r_digitCode;
  logic           r_multi;
  logic           r_bs;
  logic           r_cf;
  logic           r_op;
  logic           r_rl;
  logic           r_act;

  assign w_raw  = {kif.relieve_raw, kif.admin_raw, kif.operate_raw,
                   kif.confirm_raw, kif.backspace_raw, kif.pwds_raw};
  assign w_tick = (r_tickCnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_tickCnt <= '0;
      r_tickD   <= 1'b0;
      r_sync1   <= '0;
      r_sync2   <= '0;
    end else begin
      r_tickCnt <= w_tick ? '0 : r_tickCnt + 1'b1;
      r_tickD   <= w_tick;
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
    end
  end

  // r_debOld keeps the pre-tick levels so the following cycle can see both sides of a change
  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_deb    <= '0;
      r_debOld <= '0;
      for (int i = 0; i < NIN; i++) r_debCnt[i] <= '0;
    end else if (w_tick) begin
      r_debOld <= r_deb;
      for (int i = 0; i < NIN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_debCnt[i] <= '0;
        end else if (r_debCnt[i] == CW'(DEB_TICKS - 1)) begin
          r_deb[i]    <= r_sync2[i];
          r_debCnt[i] <= '0;
        end else begin
          r_debCnt[i] <= r_debCnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_pwdsRise = r_deb[9:0] & ~r_debOld[9:0];
  assign w_level    = r_deb[9:0];
  assign w_oneHot   = (w_level != '0) && ((w_level & (w_level - 10'd1)) == '0);

  always_comb begin
    w_digitNext = '0;
    w_codeNext  = '0;
    w_multiNext = 1'b0;
    if (w_pwdsRise != '0) begin
      if (w_oneHot) begin
        w_digitNext = w_level;
        for (int i = 0; i < 10; i++) begin
          if (w_level[i]) w_codeNext = 4'(i);
        end
      end else begin
        w_multiNext = 1'b1;
      end
    end
  end

  // Every post-tick cycle reloads the outputs, so an event lasts exactly one tick period
  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_digitPulse <= '0;
      r_digitCode  <= '0;
      r_multi      <= 1'b0;
      r_bs         <= 1'b0;
      r_cf         <= 1'b0;
      r_op         <= 1'b0;
      r_rl         <= 1'b0;
      r_act        <= 1'b0;
    end else if (r_tickD) begin
      r_digitPulse <= w_digitNext;
      r_digitCode  <= w_codeNext;
      r_multi      <= w_multiNext;
      r_bs         <= r_deb[10] & ~r_debOld[10];
      r_cf         <= r_deb[11] & ~r_debOld[11];
      r_op         <= r_deb[12] & ~r_debOld[12];
      r_rl         <= r_deb[14] & ~r_debOld[14];
      r_act        <= |(r_deb ^ r_debOld);
    end
  end

  assign kif.tick_400hz  = w_tick;
  assign kif.pwds_level  = r_deb[9:0];
  assign kif.admin_level = r_deb[13];
  assign kif.digit_pulse = r_digitPulse;
  assign kif.digit_code  = r_digitCode;
  assign kif.multi_key   = r_multi;
  assign kif.backspace_p = r_bs;
  assign kif.confirm_p   = r_cf;
  assign kif.operate_p   = r_op;
  assign kif.relieve_p   = r_rl;
  assign kif.activity_p  = r_act;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with a fast tick: expected events are
// queued when a key changes and compared when the conditioned pulse appears.
module tb_key_input_conditioner;

  localparam int TICK_DIV  = 4;
  localparam int DEB_TICKS = 3;
  // Drive lands just before a tick edge; deb moves DEB_TICKS ticks later, pulse one cycle after
  localparam int LAT = DEB_TICKS * TICK_DIV + 2;

  logic clk_100Mhz = 1'b0;
  logic reset_n    = 1'b0;

  key_input_conditioner_if kif();

  key_input_conditioner #(.TICK_DIV(TICK_DIV), .DEB_TICKS(DEB_TICKS)) dut (
    .clk_100Mhz (clk_100Mhz),
    .reset_n    (reset_n),
    .kif        (kif)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  typedef struct {
    string      tag;
    logic [19:0] pulses;
  } expT;

  expT         sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [14:0] rawState = '0;
  logic [19:0] obs;

  assign obs = {kif.digit_pulse, kif.digit_code, kif.multi_key, kif.backspace_p,
                kif.confirm_p, kif.operate_p, kif.relieve_p, kif.activity_p};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] mk(input logic [9:0] d, input logic [3:0] c, input logic m,
                                     input logic bs, input logic cf, input logic op,
                                     input logic rl, input logic act);
    return {d, c, m, bs, cf, op, rl, act};
  endfunction

  task automatic driveRaw(input logic [14:0] raw);
    rawState          = raw;
    kif.pwds_raw      = raw[9:0];
    kif.backspace_raw = raw[10];
    kif.confirm_raw   = raw[11];
    kif.operate_raw   = raw[12];
    kif.admin_raw     = raw[13];
    kif.relieve_raw   = raw[14];
  endtask

  task automatic alignTick();
    int n = 0;
    while (kif.tick_400hz !== 1'b1 && n < 10) begin
      @(negedge clk_100Mhz);
      n++;
    end
    if (n >= 10) check("align_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input string tag, input logic [14:0] raw, input logic [19:0] want);
    expT e;
    alignTick();
    driveRaw(raw);
    e.tag    = tag;
    e.pulses = want;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input int holdN);
    expT e;
    int  lat = 0;
    do begin
      @(negedge clk_100Mhz);
      lat++;
    end while (kif.activity_p !== 1'b1 && lat < 40);
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_latency"}, lat, LAT);
      check({e.tag, "_pulse"}, obs, e.pulses);
      for (int k = 1; k < holdN; k++) begin
        @(negedge clk_100Mhz);
        check({e.tag, "_hold"}, obs, e.pulses);
      end
      if (holdN == TICK_DIV) begin
        @(negedge clk_100Mhz);
        check({e.tag, "_clear"}, obs, 0);
      end
    end
  endtask

  task automatic watchQuiet(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_100Mhz);
      if (obs !== 20'h0) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int n;
    driveRaw('0);

    // Reset state and tick cadence
    repeat (5) @(negedge clk_100Mhz);
    check("reset_pulses", obs, 0);
    check("reset_level", kif.pwds_level, 0);
    check("reset_admin", kif.admin_level, 0);
    check("reset_tick", kif.tick_400hz, 0);
    reset_n = 1'b1;
    n = 0;
    do begin @(negedge clk_100Mhz); n++; end while (kif.tick_400hz !== 1'b1 && n < 10);
    check("tick_first", n, 3);
    for (int p = 0; p < 2; p++) begin
      n = 0;
      do begin @(negedge clk_100Mhz); n++; end while (kif.tick_400hz !== 1'b1 && n < 10);
      check("tick_period", n, TICK_DIV);
    end

    applyStimulus("digit5", 15'h0020, mk(10'h020, 4'd5, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    check("digit5_level", kif.pwds_level, 10'h020);

    // Confirm glitch shorter than the debounce window
    alignTick();
    driveRaw(rawState | 15'h0800);
    repeat (2 * TICK_DIV) @(negedge clk_100Mhz);
    driveRaw(rawState & ~15'h0800);
    watchQuiet("glitch_quiet", 6 * TICK_DIV);

    applyStimulus("release5", 15'h0000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("digit2", 15'h0004, mk(10'h004, 4'd2, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("multi27", 15'h0084, mk(10'h0, 4'd0, 1, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    check("multi27_level", kif.pwds_level, 10'h084);
    applyStimulus("release27", 15'h0000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("multi13_same_tick", 15'h000A, mk(10'h0, 4'd0, 1, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("release13", 15'h0000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);

    applyStimulus("bs_cf", 15'h0C00, mk(10'h0, 4'd0, 0, 1, 1, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("bs_cf_release", 15'h0000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("operate", 15'h1000, mk(10'h0, 4'd0, 0, 0, 0, 1, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("operate_release", 15'h0000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("relieve", 15'h4000, mk(10'h0, 4'd0, 0, 0, 0, 0, 1, 1));
    checkOutput(TICK_DIV);
    applyStimulus("relieve_release", 15'h0000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("admin_on", 15'h2000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    check("admin_level_on", kif.admin_level, 1);
    applyStimulus("admin_off", 15'h0000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    check("admin_level_off", kif.admin_level, 0);
    applyStimulus("digit9", 15'h0200, mk(10'h200, 4'd9, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("release9", 15'h0000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);

    // Reset two cycles into a digit pulse, between clock edges
    applyStimulus("rst_digit4", 15'h0010, mk(10'h010, 4'd4, 0, 0, 0, 0, 0, 1));
    checkOutput(2);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_pulses", obs, 0);
    check("rst_async_level", kif.pwds_level, 0);
    driveRaw('0);
    repeat (3) @(negedge clk_100Mhz);
    reset_n = 1'b1;
    watchQuiet("rst_release_quiet", 8 * TICK_DIV);
    applyStimulus("post_rst_digit6", 15'h0040, mk(10'h040, 4'd6, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);
    applyStimulus("release6", 15'h0000, mk(10'h0, 4'd0, 0, 0, 0, 0, 0, 1));
    checkOutput(TICK_DIV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
